// File: rtl/button_debounce_pkg.sv
// Shared board constants for the button front end: default sizing, channel order
// and width helpers used by the debounce blocks.
package button_debounce_pkg;

  localparam int DEF_CHANNELS     = 6;
  localparam int DEF_TICK_DIV     = 16000;
  localparam int DEF_STABLE_TICKS = 5;

  typedef enum logic [2:0] {
    CH_A     = 3'd0,
    CH_B     = 3'd1,
    CH_UP    = 3'd2,
    CH_DOWN  = 3'd3,
    CH_LEFT  = 3'd4,
    CH_RIGHT = 3'd5
  } chan_idx_e;

  function automatic int cnt_width(input int stable_ticks);
    return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
  endfunction

  function automatic int div_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, tick-qualified persistence counter,
// accepted level and registered press/release pulses.
module button_debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic             meta_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0       <= 1'b0;
      sync_p1       <= 1'b0;
      stable        <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // synchronizer stage boundary: meta_p0 -> sync_p1
      meta_p0       <= raw;
      sync_p1       <= meta_p0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == LAST) begin
          stable        <= sync_p1;
          cnt           <= '0;
          press_pulse   <= sync_p1;
          release_pulse <= ~sync_p1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Board button debouncer: shared sample-tick prescaler feeding independent
// per-channel debounce blocks; outputs are active-low levels plus edge pulses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_n,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic                any_change
);

  logic                tick;
  logic [CHANNELS-1:0] stable;

  generate
    if (TICK_DIV <= 1) begin : g_tick_every
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int DIV_W = div_width(TICK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
      logic [DIV_W-1:0] div_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      assign tick = (div_cnt == DIV_LAST);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      button_debounce_chan #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .raw          (btn_raw[i]),
        .stable       (stable[i]),
        .press_pulse  (btn_press[i]),
        .release_pulse(btn_release[i])
      );
    end
  endgenerate

  assign btn_n      = ~stable;
  assign any_change = |(btn_press | btn_release);

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with TICK_DIV=4, STABLE_TICKS=3: a table of
// level segments with pulse tallies, plus hand sequences for timing corner cases.
module tb_button_debounce;

  localparam int CH = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] btn_raw = '0;
  logic [CH-1:0] btn_n;
  logic [CH-1:0] btn_press;
  logic [CH-1:0] btn_release;
  logic          any_change;

  int checks = 0;
  int errors = 0;

  // Running pulse tallies, sampled mid-cycle.
  int press_tot = 0;
  int rel_tot   = 0;
  int any_tot   = 0;

  typedef struct {
    logic [CH-1:0] raw;
    int            cycles;
    logic [CH-1:0] exp_n;
    int            exp_press;
    int            exp_rel;
    int            exp_any;
  } row_t;

  row_t tbl [5];

  button_debounce #(
    .CHANNELS    (CH),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_n      (btn_n),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    press_tot <= press_tot + $countones(btn_press);
    rel_tot   <= rel_tot + $countones(btn_release);
    any_tot   <= any_tot + int'(any_change);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_row(input string name, input row_t r);
    int p0, r0, a0;
    p0 = press_tot; r0 = rel_tot; a0 = any_tot;
    btn_raw = r.raw;
    repeat (r.cycles) step();
    check({name, "_btn_n"}, 32'(btn_n), 32'(r.exp_n));
    check({name, "_press"}, press_tot - p0, r.exp_press);
    check({name, "_release"}, rel_tot - r0, r.exp_rel);
    check({name, "_any"}, any_tot - a0, r.exp_any);
  endtask

  initial begin
    int first;
    int nz;
    int ac;
    int p0;
    logic [CH-1:0] pv;
    logic [CH-1:0] nv;

    tbl[0] = '{6'h00, 20, 6'h3F, 0, 6, 1};
    tbl[1] = '{6'h01, 20, 6'h3E, 1, 0, 1};
    tbl[2] = '{6'h00, 20, 6'h3F, 0, 1, 1};
    tbl[3] = '{6'h04,  6, 6'h3F, 0, 0, 0};
    tbl[4] = '{6'h00, 20, 6'h3F, 0, 0, 0};

    // Reset with all buttons held, then release reset.
    rst = 1'b1;
    btn_raw = 6'h3F;
    repeat (3) step();
    check("rst_btn_n", 32'(btn_n), 32'h3F);
    check("rst_press", 32'(btn_press), 32'h0);
    check("rst_any", 32'(any_change), 32'h0);
    rst = 1'b0;
    check("rel_btn_n", 32'(btn_n), 32'h3F);
    first = 0;
    pv = '0;
    nv = '1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (first == 0 && btn_press != '0) begin
        first = i;
        pv = btn_press;
        nv = btn_n;
      end
      if (first != 0) break;
    end
    check("rst_accept_cycle", first, 12);
    check("rst_accept_press", 32'(pv), 32'h3F);
    check("rst_accept_btn_n", 32'(nv), 32'h00);
    step();
    check("rst_press_one_cycle", 32'(btn_press), 32'h0);

    // Table: release all, clean press/release of A, glitch on up.
    for (int i = 0; i < 5; i++) run_row($sformatf("row%0d", i), tbl[i]);

    // Bounce on B: ten 3-cycle segments, then a steady hold.
    p0 = press_tot;
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = (k % 2 == 0);
      repeat (3) step();
    end
    check("bounce_no_press", press_tot - p0, 0);
    check("bounce_btn_n", 32'(btn_n), 32'h3F);
    run_row("bounce_hold", '{6'h02, 20, 6'h3D, 1, 0, 1});
    run_row("bounce_release", '{6'h00, 20, 6'h3F, 0, 1, 1});

    // Down and right pressed on the same cycle.
    btn_raw = 6'b101000;
    nz = 0;
    ac = 0;
    pv = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (btn_press != '0) begin
        nz++;
        pv = btn_press;
      end
      if (any_change) ac++;
    end
    check("simul_press", 32'(pv), 32'h28);
    check("simul_press_cycles", nz, 1);
    check("simul_any_cycles", ac, 1);
    check("simul_btn_n", 32'(btn_n), 32'h17);
    run_row("simul_release", '{6'h00, 20, 6'h3F, 0, 2, 1});

    // Reset after two ticks of a left press; acceptance must restart.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    btn_raw = 6'h10;
    p0 = press_tot;
    repeat (8) step();
    rst = 1'b1;
    repeat (2) step();
    check("midrst_btn_n", 32'(btn_n), 32'h3F);
    check("midrst_press", 32'(btn_press), 32'h0);
    rst = 1'b0;
    check("midrst_no_pulse", press_tot - p0, 0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (btn_press[4]) begin
        first = i;
        break;
      end
    end
    check("midrst_accept_cycle", first, 12);
    check("midrst_btn_n_after", 32'(btn_n), 32'h2F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter CHANNELS, default 6, number of button inputs (order: A, B, up, down, left, right).
REQ-002 SHALL have parameter TICK_DIV, default 16000, sys_clk cycles per sample tick (1 ms at 16 MHz).
REQ-003 SHALL have parameter STABLE_TICKS, default 5, consecutive ticks a new level must persist before acceptance.
REQ-004 SHALL have port rst, input, 1, reset; one clock domain, and reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, core clock (sys_clk domain, the same clock as the MCU core).
REQ-006 SHALL have port btn_raw, input, CHANNELS, asynchronous board buttons, 1 = pressed.
REQ-007 SHALL have port btn_n, output, CHANNELS, debounced level for the MCU port pins, 0 = pressed.
REQ-008 SHALL have port btn_press, output, CHANNELS, one-cycle pulse per accepted press.
REQ-009 SHALL have port btn_release, output, CHANNELS, one-cycle pulse per accepted release.
REQ-010 SHALL have port any_change, output, 1, OR of btn_press and btn_release, same cycle.

Function
REQ-011 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other logic uses it.
REQ-012 SHALL run a shared prescaler counting 0..TICK_DIV-1; tick asserts for one cycle when count = TICK_DIV-1, then the count wraps to 0.
REQ-013 SHALL hold, per channel, a stable bit (1 = pressed) and a counter of width clog2(STABLE_TICKS+1).
REQ-014 SHALL clear a channel's counter on any cycle where the synchronized input equals stable, tick or not.
REQ-015 SHALL increment the counter on tick when the synchronized input differs from stable.
REQ-016 SHALL, on a tick where the counter would reach STABLE_TICKS, load stable from the synchronized input, clear the counter, and register the matching press/release pulse.
REQ-017 SHALL drive btn_n = ~stable, and SHALL drive btn_press, btn_release and any_change from registers only, with no combinational path from btn_raw.
REQ-018 SHALL make the pulse outputs visible in the cycle after the accepting tick, for exactly one cycle.
REQ-019 SHALL discard a glitch: a return to the stable level before acceptance clears the counter, with no output change.
REQ-020 SHALL treat channels independently; simultaneous acceptances on several channels pulse together, and any_change pulses once.
REQ-021 SHALL bound acceptance latency from a clean input edge to the btn_n change at 2 + STABLE_TICKS*TICK_DIV + 1 cycles worst case.
REQ-022 SHALL support TICK_DIV = 1, in which case tick is asserted every cycle.

Reset
REQ-023 SHALL, on rst high at a clk edge, clear the synchronizers, prescaler, counters and stable bits, so btn_n = all ones.
REQ-024 SHALL hold btn_press, btn_release and any_change at 0 during and after reset.
REQ-025 SHALL NOT generate a press pulse on the first acceptance after reset unless the accepted level is pressed.
REQ-026 SHALL abandon any in-progress count on rst asserted mid-count; acceptance restarts from zero.

Structure
REQ-027 SHALL place the default TICK_DIV (16000), STABLE_TICKS (5) and CHANNELS (6) constants, and the channel index constants, in the shared board package.
REQ-028 SHALL implement the per-channel synchronizer, counter, stable bit and pulse registers as sub-module button_debounce_chan.
REQ-029 SHALL have the top level hold only the shared prescaler, the generate loop and the any_change reduction.

Verification (TICK_DIV=4, STABLE_TICKS=3)
REQ-030 SHALL check reset: rst high 3 cycles with btn_raw=6'h3F, then released -> btn_n=6'h3F at release, and no pulse until accepted; then btn_press=6'h3F, btn_n=6'h00 within 15 cycles.
REQ-031 SHALL check a clean press: btn_raw[0] 0->1 held -> btn_n[0] falls within 15 cycles, with one btn_press[0] pulse and one any_change pulse.
REQ-032 SHALL check a glitch: btn_raw[2] high for 6 cycles, then low -> btn_n[2] stays 1, and no pulses on any output.
REQ-033 SHALL check bounce: btn_raw[1] toggled every 3 cycles for 30 cycles, then held high -> exactly one btn_press[1] pulse, after the hold.
REQ-034 SHALL check simultaneous events: channels 3 and 5 pressed on the same cycle -> btn_press=6'b101000 for one cycle, and any_change is a single pulse.
REQ-035 SHALL check reset mid-count: press channel 4, assert rst after 2 ticks -> no pulse, btn_n[4]=1, and re-acceptance takes the full 3 ticks after rst falls.
